// File: rtl/rice_partition_scheduler.sv
// Ping-pong partition buffer that picks a Rice parameter per partition and streams it to the encoder.
// Optional macro RICE_ESCAPE_EN: emit escape parameter 4'hF plus oEscape pulse when no k fits.
module rice_partition_scheduler #(
    parameter int SAMPLE_W      = 16,
    parameter int PARTITION_LEN = 64,
    parameter int MAX_PARAM     = 14
) (
    input  logic                iClock,
    input  logic                iResetN,
    input  logic                iValid,
    input  logic [SAMPLE_W-1:0] iSample,
    input  logic                iLast,
    output logic                oReady,
    output logic                oParamValid,
    output logic [3:0]          oRiceParam,
    output logic                oValid,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oBusy
`ifdef RICE_ESCAPE_EN
    ,output logic               oEscape
`endif
);

    localparam int CNT_W = $clog2(PARTITION_LEN);
    localparam int LEN_W = CNT_W + 1;
    localparam int SUM_W = SAMPLE_W + CNT_W + 1;
    localparam int CMP_W = SUM_W + LEN_W + 16;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_HEADER, S_STREAM} state_t;

    function automatic logic [SAMPLE_W-1:0] zigzag(input logic [SAMPLE_W-1:0] n);
        return {n[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{n[SAMPLE_W-1]}};
    endfunction

    logic [SAMPLE_W-1:0] r_mem [0:1][0:PARTITION_LEN-1];
    logic [SUM_W-1:0]    r_sum [0:1];
    logic [LEN_W-1:0]    r_len [0:1];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    state_t              r_state;
    logic [3:0]          r_k;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic                r_param_valid;
    logic [3:0]          r_param;
    logic                r_out_valid;
    logic [SAMPLE_W-1:0] r_out_sample;
`ifdef RICE_ESCAPE_EN
    logic                r_escape;
`endif

    logic                w_accept;
    logic                w_close;
    logic                w_last_rd;
    logic [1:0]          w_set;
    logic [1:0]          w_clr;
    logic [1:0]          w_full_nxt;
    logic                w_wr_bank_nxt;
    logic                w_cond;

    assign w_accept      = iValid && r_ready;
    assign w_close       = w_accept && ((r_cnt == CNT_W'(PARTITION_LEN - 1)) || iLast);
    assign w_last_rd     = (r_state == S_STREAM) &&
                           (LEN_W'(r_rd_cnt) == (r_len[r_rd_bank] - LEN_W'(1)));
    // Close and free always target different banks, so the masks never collide.
    assign w_set         = w_close   ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr         = w_last_rd ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_nxt    = (r_full & ~w_clr) | w_set;
    assign w_wr_bank_nxt = r_wr_bank ^ w_close;
    assign w_cond        = ((CMP_W'(r_len[r_rd_bank]) << r_k) >= CMP_W'(r_sum[r_rd_bank]));

    assign oReady      = r_ready;
    assign oParamValid = r_param_valid;
    assign oRiceParam  = r_param;
    assign oValid      = r_out_valid;
    assign oSample     = r_out_sample;
    assign oBusy       = (|r_full) || (r_state != S_IDLE);
`ifdef RICE_ESCAPE_EN
    assign oEscape     = r_escape;
`endif

    // Sample storage; contents are meaningless unless the bank is marked full.
    always_ff @(posedge iClock) begin
        if (w_accept) begin
            r_mem[r_wr_bank][r_cnt] <= iSample;
        end
    end

    // Fill side: count, magnitude sum, partition close and bank ownership.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_sum[0]  <= '0;
            r_sum[1]  <= '0;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_ready   <= !w_full_nxt[w_wr_bank_nxt];
            if (w_accept) begin
                // Restarting the sum on the first sample keeps a bank under selection untouched.
                r_sum[r_wr_bank] <= ((r_cnt == '0) ? '0 : r_sum[r_wr_bank]) +
                                    SUM_W'(zigzag(iSample));
                if (w_close) begin
                    r_len[r_wr_bank] <= LEN_W'(r_cnt) + LEN_W'(1);
                    r_cnt            <= '0;
                end else begin
                    r_cnt            <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Issue FSM: parameter search, header pulse, then one sample per cycle.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_state       <= S_IDLE;
            r_rd_bank     <= 1'b0;
            r_k           <= 4'd0;
            r_rd_cnt      <= '0;
            r_param_valid <= 1'b0;
            r_param       <= 4'd0;
            r_out_valid   <= 1'b0;
            r_out_sample  <= '0;
`ifdef RICE_ESCAPE_EN
            r_escape      <= 1'b0;
`endif
        end else begin
            r_param_valid <= 1'b0;
`ifdef RICE_ESCAPE_EN
            r_escape      <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= S_SELECT;
                        r_k     <= 4'd0;
                    end
                end
                S_SELECT: begin
                    if (w_cond) begin
                        r_param       <= r_k;
                        r_param_valid <= 1'b1;
                        r_state       <= S_HEADER;
                    end else if (r_k == 4'(MAX_PARAM)) begin
`ifdef RICE_ESCAPE_EN
                        r_param       <= 4'hF;
                        r_escape      <= 1'b1;
`else
                        r_param       <= r_k;
`endif
                        r_param_valid <= 1'b1;
                        r_state       <= S_HEADER;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_HEADER: begin
                    r_out_sample <= r_mem[r_rd_bank][CNT_W'(0)];
                    r_out_valid  <= 1'b1;
                    r_rd_cnt     <= '0;
                    r_state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_last_rd) begin
                        r_out_valid <= 1'b0;
                        r_rd_bank   <= ~r_rd_bank;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_sample <= r_mem[r_rd_bank][r_rd_cnt + CNT_W'(1)];
                        r_rd_cnt     <= r_rd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
